// File: rtl/vga_pkg.sv
// Shared timing defaults and helpers for the generic VGA timing generator.
package vga_pkg;

  // 640x480@60 with a 25 MHz pixel clock
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  typedef logic [23:0] rgb_t;

  // Total clocks per line (or lines per frame) for one axis
  function automatic int timing_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // True when a cw-bit counter can reach total-1
  function automatic bit cw_fits(input int cw, input int total);
    return (total - 1) < (1 << cw);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with a configurable reset pattern.
module vga_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;

  // Shift d_i through DEPTH stages; reset loads the idle pattern everywhere
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= {DEPTH{RESET_VAL}};
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Generic VGA raster timing with latency-matched sync/blank/RGB and
// request/acknowledge double-buffer flipping at the start of vertical blank.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_LAT = 2,
  parameter int CW       = 10
) (
  input  logic          CLOCK_25,
  input  logic          reset,
  input  rgb_t          c_in,
  input  logic          swap_req,
  output logic          swap_ack,
  output logic          current_buffer,
  output logic [CW-1:0] oX,
  output logic [CW-1:0] oY,
  output logic          fetch_valid,
  output logic          frame_start,
  output logic          VGA_CLK,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic [7:0]    VGA_R,
  output logic [7:0]    VGA_G,
  output logic [7:0]    VGA_B
);

  localparam int H_TOT = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CW-1:0] H_LAST  = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VB_LINE = CW'(V_ACTIVE - 1);
  // One extra bit so a sync window ending exactly at 2**CW still compares
  localparam logic [CW:0]   HS_START = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0]   HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0]   VS_START = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0]   VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

  if (!cw_fits(CW, H_TOT) || !cw_fits(CW, V_TOT)) begin : g_cw_too_narrow
    $error("vga_timing_gen: CW too narrow for H_TOT/V_TOT");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_bad_pipe_lat
    $error("vga_timing_gen: PIPE_LAT must be 0..7");
  end

  logic [CW-1:0] h_q, h_d, v_q, v_d;
  logic [CW-1:0] ox_q, oy_q;
  logic          ovld_q;
  logic          pend_q, pend_d, buf_q, buf_d;
  logic          at_vblank;
  logic          hs_raw, vs_raw, act_raw;
  logic          hs_dly, vs_dly, act_dly;
  logic          hs_q, vs_q, bn_q;
  rgb_t          rgb_q;

  // Raster position: h wraps at H_TOT-1, v advances on every h wrap
  always_comb begin
    h_d = h_q + CW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
    end
  end

  // Counters plus the registered fetch coordinates one clock behind them
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      ovld_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      ox_q   <= h_q;
      oy_q   <= v_q;
      ovld_q <= 1'b1;
    end
  end

  assign oX          = ox_q;
  assign oY          = oy_q;
  assign fetch_valid = (ox_q < H_ACT) && (oy_q < V_ACT);
  // ovld_q keeps the held-reset (0,0) from looking like a frame start
  assign frame_start = ovld_q && (ox_q == '0) && (oy_q == '0);

  // Flip only on the last clock of the last active line
  assign at_vblank = (h_q == H_LAST) && (v_q == VB_LINE);
  assign swap_ack  = !reset && at_vblank && (pend_q || swap_req);

  // Pending latches any request not yet acknowledged; an ack consumes it
  always_comb begin
    pend_d = pend_q;
    buf_d  = buf_q;
    if (swap_ack) begin
      pend_d = 1'b0;
      buf_d  = ~buf_q;
    end else if (swap_req) begin
      pend_d = 1'b1;
    end
  end

  // Swap state register
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      pend_q <= 1'b0;
      buf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      buf_q  <= buf_d;
    end
  end

  assign current_buffer = buf_q;

  // Internal sync/active flags are active-high; polarity is applied at the pins
  assign hs_raw  = ({1'b0, h_q} >= HS_START) && ({1'b0, h_q} < HS_END);
  assign vs_raw  = ({1'b0, v_q} >= VS_START) && ({1'b0, v_q} < VS_END);
  assign act_raw = (h_q < H_ACT) && (v_q < V_ACT);

  // PIPE_LAT+1 stages lines the flags up with c_in for the same pixel
  vga_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_LAT + 1),
    .RESET_VAL(3'b000)
  ) u_dly (
    .clk_i(CLOCK_25),
    .rst_i(reset),
    .d_i  ({hs_raw, vs_raw, act_raw}),
    .q_o  ({hs_dly, vs_dly, act_dly})
  );

  // Output register: colour forced to black outside the active region
  always_ff @(posedge CLOCK_25) begin
    if (reset) begin
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
      bn_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs_dly;
      vs_q  <= vs_dly;
      bn_q  <= act_dly;
      rgb_q <= act_dly ? c_in : '0;
    end
  end

  assign VGA_CLK             = CLOCK_25;
  assign VGA_HS              = HS_POL ? hs_q : ~hs_q;
  assign VGA_VS              = VS_POL ? vs_q : ~vs_q;
  assign VGA_BLANK_N         = bn_q;
  assign VGA_SYNC_N          = 1'b1;
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;

endmodule
